// File: rtl/smc_sort_buffer.sv
// rtl/smc_sort_buffer.sv - six-value insertion sort buffer feeding the SMC choose stage
// Each accepted beat is inserted in one cycle; the sorted frame is published on completion.
module smc_sort_buffer #(
   parameter int WIDTH   = 10,
   parameter int DESCEND = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [1:0]       in_mode,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [1:0]       mode,
   output logic [WIDTH-1:0] n0,
   output logic [WIDTH-1:0] n1,
   output logic [WIDTH-1:0] n2,
   output logic [WIDTH-1:0] n3,
   output logic [WIDTH-1:0] n4,
   output logic [WIDTH-1:0] n5
);

   typedef enum logic {LOAD, DONE} state_t;

   state_t           state, state_nx;
   logic [2:0]       count;
   logic [1:0]       mode_r;
   logic [WIDTH-1:0] slot [6];
   logic [WIDTH-1:0] ins  [6];
   logic [5:0]       keep;
   logic             accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= LOAD;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid && count == 3'd5) state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            state_nx  = LOAD;
         end
         default: state_nx = LOAD;
      endcase
   end

   assign accept = in_valid && in_ready;

   // keep[i]: occupied slot that stays ahead of the new value (ties stay ahead for stability)
   always_comb begin
      keep = '0;
      for (int i = 0; i < 6; i++) begin
         if (i < int'(count)) begin
            if (DESCEND != 0) keep[i] = (slot[i] >= in_data);
            else              keep[i] = (slot[i] <= in_data);
         end
      end
   end

   always_comb begin
      ins[0] = keep[0] ? slot[0] : in_data;
      for (int i = 1; i < 6; i++) begin
         if (keep[i])        ins[i] = slot[i];
         else if (keep[i-1]) ins[i] = in_data;
         else                ins[i] = slot[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= '0;
         mode_r <= '0;
         mode   <= '0;
         for (int i = 0; i < 6; i++) slot[i] <= '0;
         n0 <= '0; n1 <= '0; n2 <= '0; n3 <= '0; n4 <= '0; n5 <= '0;
      end else if (state == DONE) begin
         count <= '0;
      end else if (accept) begin
         for (int i = 0; i < 6; i++) slot[i] <= ins[i];
         count <= count + 3'd1;
         if (count == 3'd0) mode_r <= in_mode;
         // Publish straight from the insert network so results appear with out_valid
         if (count == 3'd5) begin
            mode <= mode_r;
            n0 <= ins[0]; n1 <= ins[1]; n2 <= ins[2];
            n3 <= ins[3]; n4 <= ins[4]; n5 <= ins[5];
         end
      end
   end

endmodule

// File: tb/tb_smc_sort_buffer.sv
// tb/tb_smc_sort_buffer.sv - self-checking bench for smc_sort_buffer
// A descending and an ascending instance share the same stimulus.
module tb_smc_sort_buffer;

   localparam int W = 10;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic [1:0]   in_mode = 2'b00;
   logic [W-1:0] in_data = '0;

   logic         in_ready, out_valid, in_ready_a, out_valid_a;
   logic [1:0]   mode, mode_a;
   logic [W-1:0] n0, n1, n2, n3, n4, n5;
   logic [W-1:0] a0, a1, a2, a3, a4, a5;

   int checks = 0;
   int failures = 0;
   int pulses = 0;

   always #5 clk = ~clk;

   smc_sort_buffer #(.WIDTH(W), .DESCEND(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_mode(in_mode), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .mode(mode),
      .n0(n0), .n1(n1), .n2(n2), .n3(n3), .n4(n4), .n5(n5));

   smc_sort_buffer #(.WIDTH(W), .DESCEND(0)) dut_asc (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_mode(in_mode), .in_data(in_data),
      .in_ready(in_ready_a), .out_valid(out_valid_a), .mode(mode_a),
      .n0(a0), .n1(a1), .n2(a2), .n3(a3), .n4(a4), .n5(a5));

   always @(negedge clk) if (out_valid) pulses++;

   typedef struct {
      int         d [6];
      logic [1:0] m1;
      logic [1:0] mrest;
      int         gap_after2;
      int         desc [6];
      int         asc [6];
      logic [1:0] exp_mode;
   } vec_t;

   vec_t vecs [4];

   function automatic logic [63:0] pack6(input int v [6]);
      logic [63:0] r = '0;
      for (int i = 0; i < 6; i++) r = (r << W) | 64'(v[i] & ((1 << W) - 1));
      return r;
   endfunction

   function automatic logic [63:0] got_desc();
      return 64'({n0, n1, n2, n3, n4, n5});
   endfunction

   function automatic logic [63:0] got_asc();
      return 64'({a0, a1, a2, a3, a4, a5});
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Entered at a negedge; presents a beat and returns at the negedge after it is accepted.
   task automatic beat(input int d, input logic [1:0] m, output int stalls);
      int budget = 20;
      stalls = 0;
      in_valid = 1'b1;
      in_data  = W'(d);
      in_mode  = m;
      while (!in_ready && budget > 0) begin
         @(negedge clk);
         stalls++;
         budget--;
      end
      if (!in_ready) chk("beat_timeout", 64'(in_ready), 64'd1);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic frame(input int d [6], input logic [1:0] m1, input logic [1:0] mrest, input int gap);
      int s;
      for (int i = 0; i < 6; i++) begin
         beat(d[i], (i == 0) ? m1 : mrest, s);
         if (i == 1 && gap > 0) idle(gap);
      end
   endtask

   initial begin
      int s;
      int base;
      int e [6];
      vecs[0] = '{d:'{14,30,3,11,1,4}, m1:2'b00, mrest:2'b00, gap_after2:0,
                  desc:'{30,14,11,4,3,1}, asc:'{1,3,4,11,14,30}, exp_mode:2'b00};
      vecs[1] = '{d:'{14,30,3,11,1,4}, m1:2'b10, mrest:2'b01, gap_after2:2,
                  desc:'{30,14,11,4,3,1}, asc:'{1,3,4,11,14,30}, exp_mode:2'b10};
      vecs[2] = '{d:'{5,1023,0,5,0,1023}, m1:2'b11, mrest:2'b00, gap_after2:0,
                  desc:'{1023,1023,5,5,0,0}, asc:'{0,0,5,5,1023,1023}, exp_mode:2'b11};
      vecs[3] = '{d:'{0,0,0,0,0,0}, m1:2'b01, mrest:2'b10, gap_after2:1,
                  desc:'{0,0,0,0,0,0}, asc:'{0,0,0,0,0,0}, exp_mode:2'b01};

      #1;
      chk("reset_outputs", got_desc(), 64'd0);
      chk("reset_mode", 64'(mode), 64'd0);
      chk("reset_valid", 64'(out_valid), 64'd0);
      chk("reset_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 4; v++) begin
         base = pulses;
         frame(vecs[v].d, vecs[v].m1, vecs[v].mrest, vecs[v].gap_after2);
         chk($sformatf("vec%0d_valid", v), 64'(out_valid), 64'd1);
         chk($sformatf("vec%0d_desc", v), got_desc(), pack6(vecs[v].desc));
         chk($sformatf("vec%0d_asc", v), got_asc(), pack6(vecs[v].asc));
         chk($sformatf("vec%0d_mode", v), 64'(mode), 64'(vecs[v].exp_mode));
         chk($sformatf("vec%0d_ready_done", v), 64'(in_ready), 64'd0);
         idle(1);
         chk($sformatf("vec%0d_valid_fall", v), 64'(out_valid), 64'd0);
         chk($sformatf("vec%0d_hold", v), got_desc(), pack6(vecs[v].desc));
         idle(1);
         chk($sformatf("vec%0d_pulses", v), 64'(pulses - base), 64'd1);
      end

      // Back-to-back frames with in_valid held high across DONE
      base = pulses;
      for (int i = 0; i < 6; i++) beat(6 - i, 2'b01, s);
      e = '{6,5,4,3,2,1};
      chk("b2b_a_desc", got_desc(), pack6(e));
      chk("b2b_a_valid", 64'(out_valid), 64'd1);
      for (int i = 0; i < 6; i++) begin
         beat(i + 1, 2'b10, s);
         if (i == 0) chk("b2b_done_stall", 64'(s), 64'd1);
      end
      chk("b2b_b_desc", got_desc(), pack6(e));
      e = '{1,2,3,4,5,6};
      chk("b2b_b_asc", got_asc(), pack6(e));
      chk("b2b_b_mode", 64'(mode), 64'd2);
      idle(2);
      chk("b2b_pulses", 64'(pulses - base), 64'd2);

      // Reset in the middle of a frame
      frame('{14,30,3,11,1,4}, 2'b11, 2'b11, 0);
      idle(1);
      for (int i = 0; i < 3; i++) beat(50 + i, 2'b01, s);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("midrst_outputs", got_desc(), 64'd0);
      chk("midrst_mode", 64'(mode), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      frame('{9,8,7,6,5,4}, 2'b10, 2'b00, 0);
      e = '{9,8,7,6,5,4};
      chk("midrst_frame", got_desc(), pack6(e));
      chk("midrst_mode2", 64'(mode), 64'd2);
      idle(1);

      // Outputs hold across a partial frame
      frame('{14,30,3,11,1,4}, 2'b00, 2'b00, 0);
      idle(1);
      e = '{30,14,11,4,3,1};
      for (int i = 0; i < 5; i++) begin
         beat(100, 2'b11, s);
         chk($sformatf("hold_valid%0d", i), 64'(out_valid), 64'd0);
         chk($sformatf("hold_data%0d", i), got_desc(), pack6(e));
      end
      beat(100, 2'b11, s);
      e = '{100,100,100,100,100,100};
      chk("hold_final_valid", 64'(out_valid), 64'd1);
      chk("hold_final_data", got_desc(), pack6(e));
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
